// File: rtl/meas_pkg.sv
// ----------------------------------------------------------------------------
// meas_pkg
// Shared definitions for the measurement scheduler:
//   - meas_state_e          : sweep sequencer states
//   - VALID_BIT/TO_BIT/...  : result-buffer word field positions
//   - DEFAULT_SETTLE_CYCLES : default mux settle time in clock cycles
// ----------------------------------------------------------------------------
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        SETTLE,
        MEASURE,
        STORE,
        DONE
    } meas_state_e;

    // Result word layout: {valid, timeout, 4'b0, average}
    localparam int unsigned RES_W     = 16;
    localparam int unsigned VALID_BIT = 15;
    localparam int unsigned TO_BIT    = 14;
    localparam int unsigned AVG_LSB   = 0;

    localparam int unsigned DEFAULT_SETTLE_CYCLES = 16;

endpackage

// File: rtl/next_chan_find.sv
// ----------------------------------------------------------------------------
// next_chan_find
// Purely combinational priority finder: returns the lowest set bit of i_mask
// whose index is >= i_cur.
// Ports:
//   i_mask   in  NUM_CHAN  pending channel mask
//   i_cur    in  SEL_W     lowest index to consider
//   o_found  out 1         a qualifying bit exists
//   o_index  out SEL_W     index of that bit (0 when none)
// ----------------------------------------------------------------------------
module next_chan_find #(
    parameter int unsigned NUM_CHAN = 32,
    parameter int unsigned SEL_W    = 5
) (
    input  logic [NUM_CHAN-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    output logic                o_found,
    output logic [SEL_W-1:0]    o_index
);

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        // Ascending scan; the first hit locks out all higher indices.
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (!o_found && i_mask[i] && (i >= 32'(i_cur))) begin
                o_found = 1'b1;
                o_index = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/meas_scheduler.sv
// ----------------------------------------------------------------------------
// meas_scheduler
// Sequences the frequency-counter measurement core across up to NUM_CHAN
// channels. On start it latches the channel mask, then for each enabled
// channel: selects the mux input, waits SETTLE_CYCLES, enables the counter
// core until done_flag, and writes {valid, timeout, 4'b0, average} to the
// result buffer at address = channel. irq_out is raised when a sweep ends.
//
// Optional feature macro: MEAS_SCHED_TIMEOUT_EN
//   defined   : MEASURE gives up after timeout_cfg cycles (timeout bit set)
//   undefined : MEASURE waits for done_flag or abort; timeout_cfg unused
//
// Ports:
//   Clock, nReset      clock / async active-low reset
//   start              one-cycle pulse, begins a sweep when idle
//   abort              level, cancels a sweep in progress
//   chan_mask          channels to measure (bit n = channel n)
//   samples_cfg        samples per measurement (latched at start)
//   timeout_cfg        cycles allowed per measurement
//   select_input       counter-core input mux select
//   samples_required   latched samples_cfg to counter core
//   enable             counter-core run enable
//   done_flag, average counter-core result valid / averaged result
//   res_wr_en, res_addr, res_data   result buffer write port
//   busy               sweep in progress
//   irq_out, irq_ack   sweep-complete interrupt and its clear
// ----------------------------------------------------------------------------
module meas_scheduler
    import meas_pkg::*;
#(
    parameter int unsigned NUM_CHAN      = 32,
    parameter int unsigned SEL_W         = 5,
    parameter int unsigned AVG_W         = 10,
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned TO_W          = 24
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_CHAN-1:0] chan_mask,
    input  logic [15:0]         samples_cfg,
    input  logic [TO_W-1:0]     timeout_cfg,
    output logic [SEL_W-1:0]    select_input,
    output logic [15:0]         samples_required,
    output logic                enable,
    input  logic                done_flag,
    input  logic [AVG_W-1:0]    average,
    output logic                res_wr_en,
    output logic [SEL_W-1:0]    res_addr,
    output logic [RES_W-1:0]    res_data,
    output logic                busy,
    output logic                irq_out,
    input  logic                irq_ack
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    meas_state_e         r_state;
    logic [NUM_CHAN-1:0] r_mask;
    logic [SEL_W-1:0]    r_cur;
    logic [SEL_W-1:0]    r_sel;
    logic [15:0]         r_samples;
    logic                r_enable;
    logic                r_wr_en;
    logic [SEL_W-1:0]    r_addr;
    logic [RES_W-1:0]    r_data;
    logic                r_busy;
    logic                r_irq;
    logic [SCNT_W-1:0]   r_settle_cnt;

    logic                w_found;
    logic [SEL_W-1:0]    w_index;
    logic                w_meas_to;
    logic [RES_W-1:0]    w_res_word;

    next_chan_find #(
        .NUM_CHAN (NUM_CHAN),
        .SEL_W    (SEL_W)
    ) u_find (
        .i_mask  (r_mask),
        .i_cur   (r_cur),
        .o_found (w_found),
        .o_index (w_index)
    );

`ifdef MEAS_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    // Counts MEASURE cycles; held at zero in every other state so it is
    // already cleared on MEASURE entry.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_to_cnt <= '0;
        end else if (r_state != MEASURE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Fires on the timeout_cfg-th MEASURE cycle; done_flag has priority.
    assign w_meas_to = (r_state == MEASURE) && !done_flag &&
                       ((r_to_cnt + TO_W'(1)) >= timeout_cfg);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^timeout_cfg;
    assign w_meas_to = 1'b0;
`endif

    always_comb begin
        w_res_word            = '0;
        w_res_word[VALID_BIT] = 1'b1;
        w_res_word[TO_BIT]    = w_meas_to;
        if (!w_meas_to) begin
            w_res_word[AVG_LSB +: AVG_W] = average;
        end
    end

    // Outputs are registered; the write strobe and result word are loaded
    // on the MEASURE->STORE edge so they are valid during the STORE cycle.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_cur        <= '0;
            r_sel        <= '0;
            r_samples    <= '0;
            r_enable     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_irq        <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (irq_ack) begin
                r_irq <= 1'b0;
            end

            if (abort && (r_state != IDLE)) begin
                // Abort outranks every transition, including the one that
                // would load a STORE write or raise the interrupt.
                r_state  <= IDLE;
                r_enable <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_mask    <= chan_mask;
                            r_samples <= samples_cfg;
                            r_cur     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (w_found) begin
                            r_sel        <= w_index;
                            r_cur        <= w_index;
                            r_settle_cnt <= '0;
                            r_state      <= SETTLE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                    SETTLE: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            r_enable <= 1'b1;
                            r_state  <= MEASURE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SCNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (done_flag || w_meas_to) begin
                            r_enable <= 1'b0;
                            r_wr_en  <= 1'b1;
                            r_addr   <= r_cur;
                            r_data   <= w_res_word;
                            r_state  <= STORE;
                        end
                    end
                    STORE: begin
                        // cur wraps at NUM_CHAN-1; the mask is empty by then.
                        r_mask[r_cur] <= 1'b0;
                        r_cur         <= r_cur + SEL_W'(1);
                        r_state       <= SEARCH;
                    end
                    DONE: begin
                        // Placed after the ack clear so a coincident set wins.
                        r_irq   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign select_input     = r_sel;
    assign samples_required = r_samples;
    assign enable           = r_enable;
    assign res_wr_en        = r_wr_en;
    assign res_addr         = r_addr;
    assign res_data         = r_data;
    assign busy             = r_busy;
    assign irq_out          = r_irq;

endmodule

// File: doc/meas_scheduler.md
Name: meas_scheduler

Overview:
- Sequences the frequency-counter measurement core across up to 32 Superchip output channels.
- On `start`, walks a latched channel mask. For each enabled channel it:
  - drives the input mux select,
  - waits a settle period,
  - enables the counter core and waits for `done_flag`,
  - writes the averaged result into a result buffer.
- Raises `irq_out` when the whole sweep completes.
- Sits between the register/control interface and the counter/averaging datapath.

Parameters:
- NUM_CHAN, 32, number of selectable channels (power of two, ≤32)
- SEL_W, 5, select_input width (log2 NUM_CHAN)
- AVG_W, 10, width of the average result
- SETTLE_CYCLES, 16, idle cycles after a mux change before enable (≥1)
- TO_W, 24, width of the measurement timeout counter

Ports:
- Clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- abort  in  1  level; cancels a sweep in progress
- chan_mask  in  NUM_CHAN  channels to measure, bit n = channel n
- samples_cfg  in  16  samples per measurement
- timeout_cfg  in  TO_W  cycles allowed per measurement
- select_input  out  SEL_W  counter-core input mux select
- samples_required  out  16  to counter core
- enable  out  1  counter-core run enable
- done_flag  in  1  counter core result valid (level)
- average  in  AVG_W  counter core averaged result
- res_wr_en  out  1  result buffer write strobe
- res_addr  out  SEL_W  result buffer address = channel number
- res_data  out  16  {valid, timeout, 4'b0, average}
- busy  out  1  sweep in progress
- irq_out  out  1  sweep complete interrupt
- irq_ack  in  1  clears irq_out

Behaviour:
- Clock and reset: single clock `Clock`; asynchronous active-low reset `nReset`.
- Reset values: every output is 0 and the state is IDLE.
- IDLE:
  - `start`=1 latches chan_mask→mask_q, samples_cfg→samples_required, sets cur=0, goes to SEARCH, `busy`=1 next cycle.
  - `start` outside IDLE is ignored.
- SEARCH (1 cycle):
  - Finds the lowest set bit of mask_q at index ≥cur.
  - Found: select_input←index, cur←index, go to SETTLE.
  - None: go to DONE.
  - mask_q=0 therefore goes straight to DONE with no writes.
- SETTLE:
  - `enable`=0 and a counter runs SETTLE_CYCLES cycles.
  - Then `enable`←1 and the state goes to MEASURE.
  - `done_flag` is ignored in SETTLE.
- MEASURE:
  - `enable` held at 1; timeout counter cleared on entry.
  - `done_flag`=1: capture `average`, go to STORE with timeout bit = 0.
  - Counter reaches timeout_cfg first: go to STORE with timeout bit = 1 and average field = 0.
  - If both happen in the same cycle, `done_flag` wins.
- STORE (1 cycle):
  - `enable`=0, `res_wr_en`=1, `res_addr`=cur, `res_data`={1, to, 4'b0, avg_q}.
  - Clears mask_q[cur], cur←cur+1, returns to SEARCH.
  - When cur=NUM_CHAN-1, cur wraps to 0 but mask_q is already empty, so SEARCH goes to DONE.
- DONE (1 cycle): `irq_out`←1, `busy`←0, go to IDLE.
- irq handling:
  - `irq_out` holds until `irq_ack`.
  - A set and an ack in the same cycle: the set wins.
  - A new `start` may be accepted while `irq_out`=1.
- abort:
  - In any non-IDLE state, next cycle: `enable`=0, `busy`=0, state IDLE.
  - No write and no irq; a STORE in the same cycle is suppressed.
- Mid-sweep changes: chan_mask and samples_cfg changes during a sweep have no effect.
- Reset mid-operation: immediately forces all outputs to 0, including `enable` and `res_wr_en`.
- Latency per channel: 1 (SEARCH) + SETTLE_CYCLES + measure time + 1 (STORE).

Optional Feature:
- Macro: MEAS_SCHED_TIMEOUT_EN.
- Defined: the MEASURE timeout described above is present.
- Undefined:
  - No timeout counter; `timeout_cfg` is ignored.
  - MEASURE waits indefinitely for `done_flag`, or exits via abort.
  - `res_data`[14] is always 0.

Decomposition:
- Package meas_pkg:
  - state enum (IDLE, SEARCH, SETTLE, MEASURE, STORE, DONE),
  - result word field positions (VALID_BIT=15, TO_BIT=14, AVG_LSB=0),
  - default SETTLE_CYCLES.
- Sub-module next_chan_find: purely combinational priority finder over mask and cur.
  - Outputs: found and index.
  - Isolated so it can be unit-tested exhaustively.

Test Plan:
- Basic sweep:
  - Stimulus: mask=0x00000005, samples=8, SETTLE=16; done_flag asserted 40 cycles after enable with average=20, then 21.
  - Response: select_input 0 then 2; writes addr0=0x8014, addr2=0x8015; irq_out=1; busy=0; exactly 2 writes.
- Empty mask:
  - Stimulus: mask=0, start.
  - Response: irq_out=1 within 3 cycles; no res_wr_en; enable never asserted.
- Timeout (macro defined):
  - Stimulus: mask=0x1, timeout_cfg=100, done_flag held 0.
  - Response: enable high exactly 100 cycles; write addr0=0xC000; irq_out=1.
- Abort and start-while-busy:
  - Stimulus: abort during channel 2 MEASURE of mask=0xF.
  - Response: enable=0 next cycle; no further writes; no irq; a second start mid-sweep is ignored (mask unchanged).
- Reset and irq timing:
  - Stimulus: nReset low mid-MEASURE.
  - Response: all outputs 0 asynchronously; after release, a new sweep runs normally; irq_ack coincident with DONE leaves irq_out=1.
- Last channel:
  - Stimulus: mask=0x80000000.
  - Response: select_input=31; single write to addr31; clean exit to IDLE.
